apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
APB3 initiator that turns a valid/ready command stream into single APB transfers and returns one response per command.
It sits under a DMA, debug or test-sequencer engine and drives the same APB master signal set the AHB-APB bridge produces, so it can feed the 16-slot APB decoder/mux.
Only one transfer is outstanding at a time.
A wait-state watchdog aborts transfers to slaves that never assert PREADY.

Parameters:
ADDR_W, 32, PADDR/cmd_addr width
DATA_W, 32, PWDATA/PRDATA width
TIMEOUT_CYCLES, 256, max ACCESS cycles without PREADY before abort; 0 disables the watchdog
TO_W, 9, watchdog counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
PCLK  in  1  clock; all logic on the rising edge
PRESETn  in  1  reset, asynchronous assert, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
rsp_err  out  1  PSLVERR seen or timeout
rsp_timeout  out  1  transfer aborted by watchdog
PADDR  out  ADDR_W  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Reset: all outputs 0; state IDLE.
  - cmd_ready is registered; it stays 0 during reset and rises on the first PCLK edge after PRESETn deasserts.
- FSM states: IDLE, SETUP, ACCESS, RESP. Every output is a register.
- IDLE:
  - cmd_ready=1.
  - On handshake: latch cmd_addr/write/wdata into PADDR/PWRITE/PWDATA, drive PSEL=1, PENABLE=0, cmd_ready=0, go to SETUP.
- SETUP: exactly one cycle; then PENABLE=1 and go to ACCESS.
- ACCESS:
  - PREADY=1 at an edge: capture rsp_rdata=(PWRITE?0:PRDATA) and rsp_err=PSLVERR; set rsp_timeout=0 and rsp_valid=1; drop PSEL and PENABLE; go to RESP.
  - PREADY=0: increment the watchdog.
  - Watchdog abort: when the watchdog equals TIMEOUT_CYCLES-1 with PREADY still 0 and TIMEOUT_CYCLES!=0, drop PSEL/PENABLE, set rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
  - PREADY and watchdog expiry on the same edge: PREADY wins and the response is normal.
  - Watchdog clears on entry to SETUP.
- RESP:
  - rsp_* held stable until rsp_ready.
  - On handshake: rsp_valid=0, cmd_ready=1, go to IDLE.
  - A new command can be accepted the cycle after the response handshake.
- APB rules:
  - PADDR/PWRITE/PWDATA are stable from SETUP through the last ACCESS cycle.
  - After a transfer they hold their last values; they change only on command acceptance.
  - PENABLE=1 only when PSEL=1.
- Latency: command accepted at edge 0 -> SETUP in cycle 1 -> ACCESS in cycle 2.
  - Zero-wait slave: rsp_valid=1 after edge 3.
  - Each wait state adds 1 cycle.
  - Max throughput is 1 transfer per 4 cycles when rsp_ready is held 1.
- rsp_ready while rsp_valid=0 is ignored. cmd_valid outside IDLE is ignored; the command is not lost, the upstream must hold it.
- Reset mid-transfer: PSEL/PENABLE go to 0 immediately, asynchronously. The in-flight command and response are discarded and no response is issued.
- PSLVERR is sampled only on the PREADY=1 edge in ACCESS.

Decomposition:
- Shared package apb_pkg:
  - FSM state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3);
  - default ADDR_W/DATA_W;
  - APB error-data constant 32'hDEADBEEF, used by benches to check the decoder's default response.
- One sub-module: apb_timeout_ctr (TO_W-bit counter; inputs clr, inc, limit; output expired). Instantiated once.

Test Plan:
- Write 0x12345678 to 0x40000004 with a zero-wait slave -> exactly one SETUP cycle then one ACCESS cycle; rsp_valid 3 cycles after acceptance; rsp_err=0; rsp_rdata=0.
- Read 0x40000000, slave inserts 3 wait states and returns 0xCAFEF00D -> PENABLE high for 4 cycles; rsp_rdata=0xCAFEF00D; addr/ctrl stable throughout.
- Read to an unused decoder slot (PSLVERR=1, PRDATA=0xDEADBEEF) -> rsp_err=1; rsp_timeout=0; rsp_rdata=0xDEADBEEF.
- TIMEOUT_CYCLES=8, PREADY held 0 -> PSEL drops after 8 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with PREADY on cycle 8 -> normal response.
- rsp_ready held 0 for 10 cycles with cmd_valid held 1 -> no new PSEL, cmd_ready=0, rsp_* stable; cmd_ready=1 the cycle after rsp_ready.
- PRESETn pulsed low during ACCESS -> PSEL/PENABLE=0 immediately; no rsp_valid; cmd_ready=1 on the first edge after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM encoding, default bus widths, decoder error data.
package apb_pkg;

   localparam int unsigned APB_ADDR_W = 32;
   localparam int unsigned APB_DATA_W = 32;

   // Read data returned by the APB decoder for an unused slot
   localparam logic [31:0] APB_ERR_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_e;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Wait-state watchdog: counts ACCESS cycles without PREADY, flags the last allowed one.
module apb_timeout_ctr #(
   parameter int unsigned TO_W = 9
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            inc,
   input  logic [TO_W-1:0] limit,
   output logic            expired
);

   logic [TO_W-1:0] r_cnt;

   // Counter: clear has priority over increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc) begin
         r_cnt <= r_cnt + TO_W'(1);
      end
   end

   // A zero limit disables the watchdog entirely
   always_comb begin
      expired = (limit != '0) && (r_cnt == (limit - TO_W'(1)));
   end

endmodule

// File: rtl/apb_cmd_master.sv
// APB3 initiator: one valid/ready command in, one APB transfer, one response out.
module apb_cmd_master
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W         = APB_ADDR_W,
   parameter int unsigned DATA_W         = APB_DATA_W,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned TO_W           = 9
)(
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

   apb_state_e        r_state,       w_state_nxt;
   logic              r_cmd_ready,   w_cmd_ready_nxt;
   logic              r_rsp_valid,   w_rsp_valid_nxt;
   logic [DATA_W-1:0] r_rsp_rdata,   w_rsp_rdata_nxt;
   logic              r_rsp_err,     w_rsp_err_nxt;
   logic              r_rsp_timeout, w_rsp_timeout_nxt;
   logic [ADDR_W-1:0] r_paddr,       w_paddr_nxt;
   logic              r_psel,        w_psel_nxt;
   logic              r_penable,     w_penable_nxt;
   logic              r_pwrite,      w_pwrite_nxt;
   logic [DATA_W-1:0] r_pwdata,      w_pwdata_nxt;

   logic w_to_clr;
   logic w_to_inc;
   logic w_to_expired;

   apb_timeout_ctr #(
      .TO_W (TO_W)
   ) u_timeout_ctr (
      .clk     (PCLK),
      .rst_n   (PRESETn),
      .clr     (w_to_clr),
      .inc     (w_to_inc),
      .limit   (TO_LIMIT),
      .expired (w_to_expired)
   );

   // State and output registers; reset drops PSEL/PENABLE asynchronously
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state       <= ST_IDLE;
         r_cmd_ready   <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
         r_paddr       <= '0;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_pwdata      <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_cmd_ready   <= w_cmd_ready_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_rdata   <= w_rsp_rdata_nxt;
         r_rsp_err     <= w_rsp_err_nxt;
         r_rsp_timeout <= w_rsp_timeout_nxt;
         r_paddr       <= w_paddr_nxt;
         r_psel        <= w_psel_nxt;
         r_penable     <= w_penable_nxt;
         r_pwrite      <= w_pwrite_nxt;
         r_pwdata      <= w_pwdata_nxt;
      end
   end

   // Next-state and next-output logic; everything holds unless a state says otherwise
   always_comb begin
      w_state_nxt       = r_state;
      w_cmd_ready_nxt   = r_cmd_ready;
      w_rsp_valid_nxt   = r_rsp_valid;
      w_rsp_rdata_nxt   = r_rsp_rdata;
      w_rsp_err_nxt     = r_rsp_err;
      w_rsp_timeout_nxt = r_rsp_timeout;
      w_paddr_nxt       = r_paddr;
      w_psel_nxt        = r_psel;
      w_penable_nxt     = r_penable;
      w_pwrite_nxt      = r_pwrite;
      w_pwdata_nxt      = r_pwdata;
      w_to_clr          = 1'b0;
      w_to_inc          = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_cmd_ready_nxt = 1'b1;
            if (cmd_valid && r_cmd_ready) begin
               w_paddr_nxt     = cmd_addr;
               w_pwrite_nxt    = cmd_write;
               w_pwdata_nxt    = cmd_wdata;
               w_psel_nxt      = 1'b1;
               w_penable_nxt   = 1'b0;
               w_cmd_ready_nxt = 1'b0;
               w_to_clr        = 1'b1;
               w_state_nxt     = ST_SETUP;
            end
         end

         ST_SETUP: begin
            w_penable_nxt = 1'b1;
            w_state_nxt   = ST_ACCESS;
         end

         ST_ACCESS: begin
            // PREADY beats a watchdog expiry on the same edge
            if (PREADY) begin
               w_rsp_rdata_nxt   = r_pwrite ? '0 : PRDATA;
               w_rsp_err_nxt     = PSLVERR;
               w_rsp_timeout_nxt = 1'b0;
               w_rsp_valid_nxt   = 1'b1;
               w_psel_nxt        = 1'b0;
               w_penable_nxt     = 1'b0;
               w_state_nxt       = ST_RESP;
            end else if (w_to_expired) begin
               w_rsp_rdata_nxt   = '0;
               w_rsp_err_nxt     = 1'b1;
               w_rsp_timeout_nxt = 1'b1;
               w_rsp_valid_nxt   = 1'b1;
               w_psel_nxt        = 1'b0;
               w_penable_nxt     = 1'b0;
               w_state_nxt       = ST_RESP;
            end else begin
               w_to_inc = 1'b1;
            end
         end

         ST_RESP: begin
            if (rsp_ready) begin
               w_rsp_valid_nxt = 1'b0;
               w_cmd_ready_nxt = 1'b1;
               w_state_nxt     = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Ports driven straight from registers
   assign cmd_ready   = r_cmd_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign rsp_timeout = r_rsp_timeout;
   assign PADDR       = r_paddr;
   assign PSEL        = r_psel;
   assign PENABLE     = r_penable;
   assign PWRITE      = r_pwrite;
   assign PWDATA      = r_pwdata;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master with a programmable APB slave model.
module tb_apb_cmd_master;
   import apb_pkg::*;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int          TOC = 8;
   localparam int unsigned TOW = 4;

   logic          PCLK = 1'b0;
   logic          PRESETn;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;
   logic [AW-1:0] PADDR;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [DW-1:0] PWDATA;
   logic [DW-1:0] PRDATA  = '0;
   logic          PREADY  = 1'b0;
   logic          PSLVERR = 1'b0;

   apb_cmd_master #(
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (TOC),
      .TO_W           (TOW)
   ) dut (
      .PCLK        (PCLK),
      .PRESETn     (PRESETn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .PADDR       (PADDR),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PWRITE      (PWRITE),
      .PWDATA      (PWDATA),
      .PRDATA      (PRDATA),
      .PREADY      (PREADY),
      .PSLVERR     (PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      logic        to;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   acc_cyc = 0;

   // slave configuration for the next transfer
   int          sl_wait = 0;
   logic        sl_err  = 1'b0;
   logic        sl_hang = 1'b0;
   logic [31:0] sl_data = '0;

   // monitor state
   int          acc_cnt = 0;
   int          setup_cyc = 0;
   int          pen_cyc = 0;
   int          viol = 0;
   int          pen_no_sel = 0;
   int          sel_starts = 0;
   logic        prev_sel = 1'b0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_wdata = '0;
   logic        m_wr = 1'b0;

   always @(posedge PCLK) cyc <= cyc + 1;

   // Slave model and bus monitor, evaluated mid-cycle
   always @(posedge PCLK) begin
      #2;
      if (PSEL && !PENABLE) begin
         if (!prev_sel) begin
            sel_starts++;
            setup_cyc = 0;
            pen_cyc   = 0;
            viol      = 0;
            m_addr    = PADDR;
            m_wr      = PWRITE;
            m_wdata   = PWDATA;
         end
         setup_cyc++;
      end
      if (PSEL && PENABLE) begin
         pen_cyc++;
         if (acc_cnt == sl_wait && !sl_hang) begin
            PREADY  = 1'b1;
            PRDATA  = sl_data;
            PSLVERR = sl_err;
         end else begin
            PREADY  = 1'b0;
            PRDATA  = 32'h0BAD_0BAD;
            PSLVERR = 1'b1;
         end
         acc_cnt++;
      end else begin
         PREADY  = 1'b0;
         PSLVERR = 1'b0;
         acc_cnt = 0;
      end
      if (PSEL && (PADDR !== m_addr || PWRITE !== m_wr || PWDATA !== m_wdata)) viol++;
      if (PENABLE && !PSEL) pen_no_sel++;
      prev_sel = PSEL;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive a command, wait for acceptance, push the expected response
   task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
      int   n = 0;
      exp_t e;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      while (!cmd_ready && n < 100) begin
         @(posedge PCLK); #1;
         n++;
      end
      if (!cmd_ready) begin
         check_eq("cmd_accept", 32'(cmd_ready), 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      acc_cyc = cyc;
      @(posedge PCLK);
      e.addr  = a;
      e.wr    = wr;
      e.wdata = d;
      e.to    = sl_hang || (sl_wait >= TOC);
      e.err   = e.to || sl_err;
      e.rdata = (e.to || wr) ? 32'h0 : sl_data;
      exp_q.push_back(e);
      #1;
      cmd_valid = 1'b0;
   endtask

   // Wait for a response, compare with the scoreboard, then consume it
   task automatic get_rsp(input int exp_lat);
      int   n = 0;
      exp_t e;
      while (!rsp_valid && n < 100) begin
         @(posedge PCLK); #1;
         n++;
      end
      check_eq("rsp_seen", 32'(rsp_valid), 32'd1);
      if (!rsp_valid) return;
      if (exp_lat >= 0) check_eq("latency", 32'(cyc - acc_cyc), 32'(exp_lat));
      if (exp_q.size() == 0) begin
         check_eq("sb_nonempty", 32'(exp_q.size()), 32'd1);
         return;
      end
      e = exp_q.pop_front();
      check_eq("rsp_rdata", rsp_rdata, e.rdata);
      check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
      check_eq("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
      check_eq("apb_addr", m_addr, e.addr);
      check_eq("apb_write", 32'(m_wr), 32'(e.wr));
      check_eq("apb_wdata", m_wdata, e.wdata);
      check_eq("apb_stable", 32'(viol), 32'd0);
      rsp_ready = 1'b1;
      @(posedge PCLK); #1;
      check_eq("rsp_dropped", 32'(rsp_valid), 32'd0);
      check_eq("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      int          n;
      int          bad;
      int          s0;
      logic [31:0] s_rdata;
      logic        s_err;
      logic        s_to;

      PRESETn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b1;

      // Reset values
      repeat (3) @(posedge PCLK);
      #1;
      check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_psel_pen", 32'({PSEL, PENABLE, PWRITE}), 32'd0);
      check_eq("rst_paddr", PADDR, 32'd0);
      check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
      PRESETn = 1'b1;
      check_eq("rdy_before_edge", 32'(cmd_ready), 32'd0);
      @(posedge PCLK); #1;
      check_eq("rdy_first_edge", 32'(cmd_ready), 32'd1);

      // Zero-wait write
      sl_wait = 0; sl_err = 1'b0; sl_hang = 1'b0; sl_data = 32'h1111_2222;
      send_cmd(1'b1, 32'h4000_0004, 32'h1234_5678);
      get_rsp(3);
      check_eq("wr_setup_cyc", 32'(setup_cyc), 32'd1);
      check_eq("wr_access_cyc", 32'(pen_cyc), 32'd1);
      check_eq("wr_paddr_hold", PADDR, 32'h4000_0004);
      check_eq("wr_pwdata_hold", PWDATA, 32'h1234_5678);

      // Read with three wait states
      sl_wait = 3; sl_data = 32'hCAFE_F00D;
      send_cmd(1'b0, 32'h4000_0000, 32'h0);
      get_rsp(6);
      check_eq("rd_access_cyc", 32'(pen_cyc), 32'd4);
      check_eq("rd_setup_cyc", 32'(setup_cyc), 32'd1);

      // Unused decoder slot
      sl_wait = 0; sl_err = 1'b1; sl_data = APB_ERR_DATA;
      send_cmd(1'b0, 32'h4000_F000, 32'h0);
      get_rsp(3);

      // Slave never ready: watchdog aborts after 8 ACCESS cycles
      sl_err = 1'b0; sl_hang = 1'b1; sl_data = 32'h5555_AAAA;
      send_cmd(1'b0, 32'h4000_0008, 32'h0);
      get_rsp(10);
      check_eq("to_access_cyc", 32'(pen_cyc), 32'd8);

      // PREADY on the 8th ACCESS cycle wins over expiry
      sl_hang = 1'b0; sl_wait = 7; sl_data = 32'h7777_8888;
      send_cmd(1'b0, 32'h4000_000C, 32'h0);
      get_rsp(10);
      check_eq("edge_access_cyc", 32'(pen_cyc), 32'd8);

      // Back-to-back random traffic
      for (int i = 0; i < 6; i++) begin
         sl_wait = int'($urandom_range(0, 3));
         sl_err  = 1'($urandom_range(0, 1));
         sl_data = $urandom;
         send_cmd(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom);
         get_rsp(3 + sl_wait);
      end

      // Response backpressure with the next command held
      sl_wait = 1; sl_err = 1'b0; sl_data = 32'hA5A5_0001;
      rsp_ready = 1'b0;
      send_cmd(1'b0, 32'h4000_0010, 32'h0);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_0014; cmd_wdata = 32'h0000_BEEF;
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(posedge PCLK); #1;
         n++;
      end
      s_rdata = rsp_rdata; s_err = rsp_err; s_to = rsp_timeout; s0 = sel_starts; bad = 0;
      repeat (10) begin
         @(posedge PCLK); #1;
         if (cmd_ready !== 1'b0 || PSEL !== 1'b0 || rsp_valid !== 1'b1 ||
             rsp_rdata !== s_rdata || rsp_err !== s_err || rsp_timeout !== s_to) bad++;
      end
      check_eq("bp_stable", 32'(bad), 32'd0);
      check_eq("bp_no_sel", 32'(sel_starts), 32'(s0));
      get_rsp(-1);
      sl_wait = 0;
      send_cmd(1'b1, 32'h4000_0014, 32'h0000_BEEF);
      get_rsp(3);

      // Reset pulsed during ACCESS
      sl_hang = 1'b1;
      send_cmd(1'b0, 32'h4000_0020, 32'h0);
      n = 0;
      while (!PENABLE && n < 20) begin
         @(posedge PCLK); #1;
         n++;
      end
      check_eq("rst_reach_access", 32'(PENABLE), 32'd1);
      #2;
      PRESETn = 1'b0;
      #1;
      check_eq("rst_async_psel", 32'(PSEL), 32'd0);
      check_eq("rst_async_penable", 32'(PENABLE), 32'd0);
      exp_q.delete();
      sl_hang = 1'b0;
      repeat (3) @(posedge PCLK);
      #1;
      check_eq("rst_no_rsp", 32'(rsp_valid), 32'd0);
      PRESETn = 1'b1;
      check_eq("rst2_rdy_before_edge", 32'(cmd_ready), 32'd0);
      @(posedge PCLK); #1;
      check_eq("rst2_rdy_first_edge", 32'(cmd_ready), 32'd1);
      repeat (3) @(posedge PCLK);
      #1;
      check_eq("rst2_still_no_rsp", 32'({rsp_valid, PSEL}), 32'd0);

      // Normal operation after the mid-transfer reset
      sl_wait = 2; sl_data = 32'h0F0F_1234;
      send_cmd(1'b0, 32'h4000_0030, 32'h0);
      get_rsp(5);

      check_eq("penable_without_psel", 32'(pen_no_sel), 32'd0);
      check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
